// File: rtl/branch_target_buffer.sv
// branch_target_buffer: direct-mapped BTB with saturating direction counters and statistics
module branch_target_buffer #(
    parameter int ENTRIES = 16,
    parameter int ADDR_W  = 32,
    parameter int CNT_W   = 2,
    parameter int STAT_W  = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              lookup_en,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_en,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    input  logic              inval,
    output logic              mispredict,
    output logic [STAT_W-1:0] stat_lookups,
    output logic [STAT_W-1:0] stat_hits,
    output logic [STAT_W-1:0] stat_mispredicts
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_W - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_WT  = CNT_W'(1) << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WNT = CNT_WT - 1'b1;

    logic [ENTRIES-1:0] valid_q;
    logic [TAG_W-1:0]   tag_q [ENTRIES];
    logic [ADDR_W-1:0]  tgt_q [ENTRIES];
    logic [CNT_W-1:0]   cnt_q [ENTRIES];
    logic [IDX_W-1:0]   l_idx, u_idx;
    logic [TAG_W-1:0]   l_tag, u_tag;
    logic [CNT_W-1:0]   u_cnt;
    logic               u_hit;
    logic               unused_pc_bits;

    assign l_idx = lookup_pc[IDX_W+1:2];
    assign l_tag = lookup_pc[ADDR_W-1:IDX_W+2];
    assign u_idx = upd_pc[IDX_W+1:2];
    assign u_tag = upd_pc[ADDR_W-1:IDX_W+2];
    assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

    always_comb begin
        pred_hit    = valid_q[l_idx] && tag_q[l_idx] == l_tag;
        pred_taken  = pred_hit && cnt_q[l_idx][CNT_W-1];
        pred_target = pred_taken ? tgt_q[l_idx] : lookup_pc + ADDR_W'(4);
        mispredict  = upd_en && ((upd_taken != upd_pred_taken) ||
                                 (upd_taken && upd_pred_target != upd_target));
        u_hit       = valid_q[u_idx] && tag_q[u_idx] == u_tag;
        u_cnt       = upd_taken ? (cnt_q[u_idx] == '1 ? cnt_q[u_idx] : cnt_q[u_idx] + 1'b1)
                                : (cnt_q[u_idx] == '0 ? cnt_q[u_idx] : cnt_q[u_idx] - 1'b1);
    end

    // inval beats a same-cycle update; tags and targets carry no reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= '0;
            for (int i = 0; i < ENTRIES; i++) cnt_q[i] <= CNT_WNT;
        end else if (inval) begin
            valid_q <= '0;
        end else if (upd_en && u_hit) begin
            cnt_q[u_idx] <= u_cnt;
            if (upd_taken) tgt_q[u_idx] <= upd_target;
        end else if (upd_en && upd_taken) begin
            valid_q[u_idx] <= 1'b1;
            tag_q[u_idx]   <= u_tag;
            tgt_q[u_idx]   <= upd_target;
            cnt_q[u_idx]   <= CNT_WT;
        end
    end

    function automatic logic [STAT_W-1:0] sat_inc(input logic [STAT_W-1:0] v, input logic en);
        return (en && v != '1) ? v + 1'b1 : v;
    endfunction

    always_ff @(posedge CLK) begin
        if (RST) begin
            stat_lookups     <= '0;
            stat_hits        <= '0;
            stat_mispredicts <= '0;
        end else begin
            stat_lookups     <= sat_inc(stat_lookups, lookup_en);
            stat_hits        <= sat_inc(stat_hits, lookup_en && pred_hit);
            stat_mispredicts <= sat_inc(stat_mispredicts, mispredict);
        end
    end
endmodule
